// File: rtl/ftdi_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ftdi_cmd_pkg
// Description : Shared definitions for the FTDI command decoder: frame state
//               encoding, header bit positions and small elaboration-time
//               helper functions.
// Revision    : 1.0 - initial release
// ============================================================================
package ftdi_cmd_pkg;

    typedef enum logic [2:0] {
        S_HDR  = 3'd0,
        S_ADDR = 3'd1,
        S_LEN  = 3'd2,
        S_WDAT = 3'd3,
        S_RD   = 3'd4
    } state_t;

    localparam int HDR_WRITE = 0;
    localparam int HDR_INCR  = 1;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result = 0;
        while ((1 << result) < value) result = result + 1;
        return result;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ftdi_byte_packer.sv
`default_nettype none
// ============================================================================
// Module      : ftdi_byte_packer
// Description : Big-endian byte packer. Shifts bytes in MSB-first and keeps
//               the byte index within the current field.
//   clk, res_n     : clock, asynchronous active-low reset
//   i_clear        : force the byte index to zero
//   i_shift        : a byte is consumed this cycle
//   i_din          : byte being consumed
//   i_last_idx     : index of the final byte of the current field
//   o_next_value   : field value including the byte being consumed now
//   o_last         : the byte consumed now completes the field
// Revision    : 1.0 - initial release
// ============================================================================
module ftdi_byte_packer #(
    parameter int MAX_BYTES = 4,
    parameter int CNT_W     = 2
) (
    input  logic                   clk,
    input  logic                   res_n,
    input  logic                   i_clear,
    input  logic                   i_shift,
    input  logic [7:0]             i_din,
    input  logic [CNT_W-1:0]       i_last_idx,
    output logic [8*MAX_BYTES-1:0] o_next_value,
    output logic                   o_last
);

    logic [CNT_W-1:0] r_count;

    assign o_last = i_shift && (r_count == i_last_idx);

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_shift) begin
            r_count <= o_last ? '0 : r_count + 1'b1;
        end
    end

    // Only the older bytes need storage; the newest byte comes straight
    // from the input so the full field is visible in its final cycle.
    generate
        if (MAX_BYTES > 1) begin : g_shift
            logic [8*(MAX_BYTES-1)-1:0] r_value;

            always_ff @(posedge clk or negedge res_n) begin
                if (!res_n) begin
                    r_value <= '0;
                end else if (i_shift) begin
                    r_value <= o_next_value[8*(MAX_BYTES-1)-1:0];
                end
            end

            assign o_next_value = {r_value, i_din};
        end else begin : g_single
            assign o_next_value = i_din;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/ftdi_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module      : ftdi_cmd_decoder
// Description : Decodes framed commands from an FWFT RX FIFO
//               (header, address, length, optional write payload) into
//               word-wide write transfers and read requests with
//               valid/ready handshakes.
//   clk, res_n           : clock, asynchronous active-low reset
//   rx_data/rx_empty     : FIFO head byte and empty flag
//   rx_read              : FIFO pop (combinational from state and wr_valid)
//   hdr                  : header of the current/last frame
//   wr_valid/ready/addr/data : write word channel
//   rd_valid/ready/addr  : read request channel
//   busy                 : a frame is in progress
//   done                 : one-cycle pulse at frame completion
// Revision    : 1.0 - initial release
// ============================================================================
module ftdi_cmd_decoder
    import ftdi_cmd_pkg::*;
#(
    parameter int ADDR_BYTES = 1,
    parameter int LEN_BYTES  = 2,
    parameter int DATA_BYTES = 1
) (
    input  logic                    clk,
    input  logic                    res_n,
    input  logic [7:0]              rx_data,
    input  logic                    rx_empty,
    output logic                    rx_read,
    output logic [7:0]              hdr,
    output logic                    wr_valid,
    input  logic                    wr_ready,
    output logic [8*ADDR_BYTES-1:0] wr_addr,
    output logic [8*DATA_BYTES-1:0] wr_data,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic [8*ADDR_BYTES-1:0] rd_addr,
    output logic                    busy,
    output logic                    done
);

    localparam int ADDR_W    = 8 * ADDR_BYTES;
    localparam int LEN_W     = 8 * LEN_BYTES;
    localparam int DATA_W    = 8 * DATA_BYTES;
    localparam int MAX_BYTES = max3(ADDR_BYTES, LEN_BYTES, DATA_BYTES);
    localparam int CNT_W     = (clog2(MAX_BYTES) > 0) ? clog2(MAX_BYTES) : 1;
    localparam int FIELD_W   = 8 * MAX_BYTES;

    state_t              r_state;
    logic [7:0]          r_hdr;
    logic [ADDR_W-1:0]   r_addr;
    logic [LEN_W-1:0]    r_words;
    logic [DATA_W-1:0]   r_wr_data;
    logic                r_wr_valid;
    logic                r_rd_valid;
    logic                r_busy;
    logic                r_done;

    logic                w_rd_en;
    logic                w_take;
    logic                w_last;
    logic [CNT_W-1:0]    w_last_idx;
    logic [FIELD_W-1:0]  w_field;
    logic [LEN_W-1:0]    w_len;
    logic [ADDR_W-1:0]   w_addr_step;
    logic                w_final_word;

    // Byte-consuming states pop whenever possible; a write stalls input
    // while its word waits for the sink, and reads never pop.
    always_comb begin
        w_rd_en    = 1'b0;
        w_last_idx = '0;
        case (r_state)
            S_HDR:  w_rd_en = 1'b1;
            S_ADDR: begin
                w_rd_en    = 1'b1;
                w_last_idx = CNT_W'(ADDR_BYTES - 1);
            end
            S_LEN: begin
                w_rd_en    = 1'b1;
                w_last_idx = CNT_W'(LEN_BYTES - 1);
            end
            S_WDAT: begin
                w_rd_en    = !r_wr_valid;
                w_last_idx = CNT_W'(DATA_BYTES - 1);
            end
            default: w_rd_en = 1'b0;
        endcase
    end

    assign rx_read      = res_n & w_rd_en;
    assign w_take       = rx_read & ~rx_empty;
    assign w_len        = w_field[LEN_W-1:0];
    assign w_addr_step  = r_hdr[HDR_INCR] ? r_addr + 1'b1 : r_addr;
    assign w_final_word = (r_words == LEN_W'(1));

    ftdi_byte_packer #(
        .MAX_BYTES (MAX_BYTES),
        .CNT_W     (CNT_W)
    ) u_packer (
        .clk          (clk),
        .res_n        (res_n),
        .i_clear      (r_state == S_HDR),
        .i_shift      (w_take && (r_state != S_HDR)),
        .i_din        (rx_data),
        .i_last_idx   (w_last_idx),
        .o_next_value (w_field),
        .o_last       (w_last)
    );

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_state    <= S_HDR;
            r_hdr      <= '0;
            r_addr     <= '0;
            r_words    <= '0;
            r_wr_data  <= '0;
            r_wr_valid <= 1'b0;
            r_rd_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_HDR: begin
                    if (w_take) begin
                        r_hdr   <= rx_data;
                        r_busy  <= 1'b1;
                        r_state <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (w_last) begin
                        r_addr  <= w_field[ADDR_W-1:0];
                        r_state <= S_LEN;
                    end
                end
                S_LEN: begin
                    if (w_last) begin
                        r_words <= w_len;
                        if (w_len == '0) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_HDR;
                        end else if (r_hdr[HDR_WRITE]) begin
                            r_state <= S_WDAT;
                        end else begin
                            r_rd_valid <= 1'b1;
                            r_state    <= S_RD;
                        end
                    end
                end
                S_WDAT: begin
                    if (r_wr_valid) begin
                        if (wr_ready) begin
                            r_wr_valid <= 1'b0;
                            r_addr     <= w_addr_step;
                            r_words    <= r_words - 1'b1;
                            if (w_final_word) begin
                                r_done  <= 1'b1;
                                r_busy  <= 1'b0;
                                r_state <= S_HDR;
                            end
                        end
                    end else if (w_last) begin
                        r_wr_data  <= w_field[DATA_W-1:0];
                        r_wr_valid <= 1'b1;
                    end
                end
                S_RD: begin
                    if (rd_ready) begin
                        r_addr  <= w_addr_step;
                        r_words <= r_words - 1'b1;
                        if (w_final_word) begin
                            r_rd_valid <= 1'b0;
                            r_done     <= 1'b1;
                            r_busy     <= 1'b0;
                            r_state    <= S_HDR;
                        end
                    end
                end
                default: r_state <= S_HDR;
            endcase
        end
    end

    assign hdr      = r_hdr;
    assign wr_valid = r_wr_valid;
    assign wr_addr  = r_addr;
    assign wr_data  = r_wr_data;
    assign rd_valid = r_rd_valid;
    assign rd_addr  = r_addr;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule
`default_nettype wire

// File: doc/ftdi_cmd_decoder.md
# ftdi_cmd_decoder

- Parametrised command decoder for the FTDI sync byte path.
- Consumes the byte stream from the RX FIFO as frames: header byte, ADDR_BYTES address bytes, LEN_BYTES length bytes, then write payload if the frame is a write.
- Emits word-wide write transfers or read requests on valid/ready handshakes toward the register/memory side.
- Supersedes the fixed 8-bit-address, 16-bit-length, byte-value sorter, adding wide words, backpressure, auto-increment and correct zero-length handling.

## Interface
Parameters:
- ADDR_BYTES, 1: address field bytes (1..4); ADDR_W = 8*ADDR_BYTES
- LEN_BYTES, 2: length field bytes (1..2); LEN_W = 8*LEN_BYTES; length counts words
- DATA_BYTES, 1: bytes per data word (1..4); DATA_W = 8*DATA_BYTES

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock
- res_n  in  1  asynchronous active-low reset
- rx_data  in  8  FIFO head byte, valid whenever rx_empty=0 (first-word-fall-through)
- rx_empty  in  1  FIFO empty
- rx_read  out  1  FIFO pop; byte consumed in any cycle with rx_read=1 and rx_empty=0
- hdr  out  8  header of current/last frame
- wr_valid  out  1  write word available
- wr_ready  in  1  write sink accepts
- wr_addr  out  ADDR_W  write word address
- wr_data  out  DATA_W  write word
- rd_valid  out  1  read request
- rd_ready  in  1  read sink accepts
- rd_addr  out  ADDR_W  read word address
- busy  out  1  1 outside S_HDR
- done  out  1  one-cycle pulse at frame completion

## Operation
- Header: bit0 = 1 write / 0 read; bit1 = 1 address auto-increment / 0 fixed address; bits 7:2 stored in hdr, otherwise ignored.
- Multi-byte fields (address, length, data word) are big-endian, MSB byte first.
- States:
  - S_HDR: latch hdr -> S_ADDR.
  - S_ADDR: after ADDR_BYTES bytes -> S_LEN.
  - S_LEN: after LEN_BYTES bytes:
    - length 0 -> S_HDR with done pulse, no transfers.
    - write -> S_WDAT.
    - read -> S_RD.
  - S_WDAT: collect DATA_BYTES bytes, then hold the word (wr_valid=1) until wr_ready. Then count one word. Last word -> S_HDR with done pulse; otherwise collect the next word.
  - S_RD: rd_valid=1 with the current address; each rd_ready counts one word. Last word -> S_HDR with done pulse.
- rx_read:
  - S_HDR/S_ADDR/S_LEN: 1.
  - S_WDAT: 1 only while wr_valid=0.
  - S_RD: 0. Bytes queued behind a read frame stay in the FIFO.
  - Forced 0 while res_n=0.
- Byte counter: one byte-index counter, width clog2(max(ADDR_BYTES,LEN_BYTES,DATA_BYTES)), cleared on each state change. Words-remaining counter is LEN_W wide.
- Address update after each handshake: +1 if hdr[1]=1, unchanged otherwise. Wraps modulo 2^ADDR_W without affecting the frame.
- rx_empty=1 in a byte-consuming state: hold state, counters and partial word. No timeout.
- Reset at any time, including mid-frame:
  - state = S_HDR; all counters 0.
  - Outputs: hdr=0, wr_valid=0, wr_addr=0, wr_data=0, rd_valid=0, rd_addr=0, busy=0, done=0.
  - The partial frame is discarded.

## Timing
- All outputs except rx_read are registered. rx_read is combinational from state and wr_valid only, never from rx_empty.
- Write latency: wr_valid rises the cycle after the last payload byte is consumed.
- Payload throughput: DATA_BYTES+1 cycles per word at best.
- Read requests: back-to-back rd_valid, one word per cycle when rd_ready is held at 1.
- wr_addr/wr_data/rd_addr are stable while valid=1 and ready=0.
- done asserts the cycle after the final handshake, or after the final length byte for length 0, together with the return to S_HDR.
- The next frame's header may be consumed in the cycle done is high.

## Structure
- Package ftdi_cmd_pkg:
  - state encoding S_HDR, S_ADDR, S_LEN, S_WDAT, S_RD
  - header bit positions HDR_WRITE=0, HDR_INCR=1
  - shared clog2 function
- Sub-module ftdi_byte_packer: big-endian shift register (shift in byte, count, full flag); used for the address, length and data fields.

## Test plan
- Defaults, bytes 01 10 00 02 AB CD, wr_ready=1:
  - wr_valid twice at addr 0x10, data AB then CD
  - done once; hdr=01
- DATA_BYTES=2, ADDR_BYTES=2, bytes 03 12 34 00 02 DE AD BE EF:
  - writes (0x1234,0xDEAD), (0x1235,0xBEEF)
- Read frame 02 FE 00 03, rd_ready toggling 1/0:
  - rd_addr FE, FF, 00 (wrap); exactly 3 handshakes; rx_read=0 throughout S_RD
- Length 0 frame 01 20 00 00 followed by 00 30 00 01:
  - no wr_valid; done after 4th byte
  - read request at 0x30
- Write with wr_ready=0 for 5 cycles:
  - wr_valid/wr_addr/wr_data held; rx_read=0; no further bytes consumed
  - rx_empty gaps between payload bytes do not corrupt data
- res_n pulsed low after the address byte:
  - all outputs zero immediately (asynchronous)
  - the next full frame decodes correctly from S_HDR
